// File: rtl/bcd_to_bin_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin_if
//  Description : Start/done handshake bundle for the sequential BCD-to-binary
//                converter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_to_bin_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;

    modport master (
        output start, bcd_in,
        input  ready, busy, done, bin_out, err
    );

    modport slave (
        input  start, bcd_in,
        output ready, busy, done, bin_out, err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin_seq
//  Description : Packed-BCD to binary converter, reverse double-dabble, one
//                result bit per clock. Define BCD_DIGIT_CHECK_EN to flag
//                digits above 9 and skip the conversion.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    bcd_to_bin_if.slave  bus
);
    localparam int c_sr_w  = 4 * DIGITS;
    localparam int c_cnt_w = $clog2(c_sr_w + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_sr_w - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_sr_w-1:0]    r_bcd_sr;
    logic [c_sr_w-1:0]    r_bin_sr;
    logic [c_sr_w-1:0]    w_bcd_shift;
    logic [c_sr_w-1:0]    w_bcd_next;
    logic [c_sr_w-1:0]    w_bin_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [BIN_W-1:0]     r_bin_out;
    logic                 w_last;
    logic                 w_invalid;
    logic                 w_ready;
    logic                 w_busy;
    logic                 w_done;

    // Shift the combined {bcd,bin} register right by one.
    assign {w_bcd_shift, w_bin_next} = {1'b0, r_bcd_sr, r_bin_sr[c_sr_w-1:1]};
    assign w_last = (r_cnt == c_last_cnt);

    // A bit falling into a digit's MSB carries weight 5 (10/2), not 8: subtract 3.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_lane;
            assign w_lane = w_bcd_shift[4*gi +: 4];
            assign w_bcd_next[4*gi +: 4] = (w_lane >= 4'd8) ? (w_lane - 4'd3) : w_lane;
        end
    endgenerate

`ifdef BCD_DIGIT_CHECK_EN
    logic [DIGITS-1:0] w_digit_bad;
    logic              r_err;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
            assign w_digit_bad[gi] = (r_bcd_sr[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign w_invalid = |w_digit_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((r_state == S_LOAD) && w_invalid) begin
            r_err <= 1'b1;
        end else if ((r_state == S_SHIFT) && w_last) begin
            r_err <= 1'b0;
        end
    end

    assign bus.err = r_err;
`else
    assign w_invalid = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_busy       = 1'b1;
                w_state_next = w_invalid ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd_sr  <= '0;
            r_bin_sr  <= '0;
            r_cnt     <= '0;
            r_bin_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_bcd_sr <= bus.bcd_in;
                        r_bin_sr <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_invalid) begin
                        r_bin_out <= '0;
                    end
                end
                S_SHIFT: begin
                    r_bcd_sr <= w_bcd_next;
                    r_bin_sr <= w_bin_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_bin_out <= w_bin_next[BIN_W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready   = w_ready;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
    assign bus.bin_out = r_bin_out;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_to_bin_seq
//  Description : Directed vector bench for bcd_to_bin_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin_seq;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int LAT    = 4 * DIGITS + 1;

    typedef struct {
        logic [11:0] bcd;
        logic [9:0]  bin;
        logic        err;
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   done_cnt;
    int   cyc;
    vec_t vecs [10];

    bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ready"}, 32'(bus.ready), 32'd1);
        check({name, "_busy"},  32'(bus.busy),  32'd0);
        check({name, "_done"},  32'(bus.done),  32'd0);
        check({name, "_bin"},   32'(bus.bin_out), 32'd0);
        check({name, "_err"},   32'(bus.err),   32'd0);
    endtask

    task automatic run_conv(input vec_t v, input string name);
        int n;
        bit seen;
        bit bad_hs;
        logic [9:0] held;
        @(negedge clk);
        n = 0;
        while (!bus.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready_before"}, 32'(bus.ready), 32'd1);
        bus.start  = 1'b1;
        bus.bcd_in = v.bcd;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.bcd_in = 12'h777;
        bad_hs = (bus.ready !== 1'b0) || (bus.busy !== 1'b1);
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done === 1'b1) seen = 1'b1;
            else if (bus.ready !== 1'b0 || bus.busy !== 1'b1) bad_hs = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_handshake"}, 32'(bad_hs), 32'd0);
        check({name, "_latency"}, 32'(n), 32'(v.lat));
        check({name, "_bin"}, 32'(bus.bin_out), 32'(v.bin));
        check({name, "_err"}, 32'(bus.err), 32'(v.err));
        check({name, "_busy_done"}, 32'({bus.ready, bus.busy}), 32'd0);
        held = bus.bin_out;
        @(posedge clk);
        #1;
        check({name, "_pulse"}, 32'(bus.done), 32'd0);
        check({name, "_held"}, 32'(bus.bin_out), 32'(v.bin));
        if (held !== bus.bin_out) begin
            check({name, "_held_stable"}, 32'(bus.bin_out), 32'(held));
        end
    endtask

    initial begin
        int n;
        int base;
        int t_prev;
        bit seen;
        vec_t v;

        vecs[0] = '{bcd: 12'h000, bin: 10'd0,   err: 1'b0, lat: LAT};
        vecs[1] = '{bcd: 12'h999, bin: 10'd999, err: 1'b0, lat: LAT};
        vecs[2] = '{bcd: 12'h255, bin: 10'd255, err: 1'b0, lat: LAT};
        vecs[3] = '{bcd: 12'h409, bin: 10'd409, err: 1'b0, lat: LAT};
        vecs[4] = '{bcd: 12'h001, bin: 10'd1,   err: 1'b0, lat: LAT};
        vecs[5] = '{bcd: 12'h010, bin: 10'd10,  err: 1'b0, lat: LAT};
        vecs[6] = '{bcd: 12'h100, bin: 10'd100, err: 1'b0, lat: LAT};
        vecs[7] = '{bcd: 12'h512, bin: 10'd512, err: 1'b0, lat: LAT};
        vecs[8] = '{bcd: 12'h765, bin: 10'd765, err: 1'b0, lat: LAT};
        vecs[9] = '{bcd: 12'h088, bin: 10'd88,  err: 1'b0, lat: LAT};

        n_checks   = 0;
        n_errors   = 0;
        done_cnt   = 0;
        cyc        = 0;
        bus.start  = 1'b0;
        bus.bcd_in = 12'h000;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i], $sformatf("vec%0d", i));
        end

        // Start pulse during SHIFT must be ignored.
        @(negedge clk);
        base       = done_cnt;
        bus.start  = 1'b1;
        bus.bcd_in = 12'h123;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.bcd_in = 12'h777;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check("ignore_done_seen", 32'(seen), 32'd1);
        check("ignore_bin", 32'(bus.bin_out), 32'd123);
        repeat (20) @(posedge clk);
        #1;
        check("ignore_single_done", 32'(done_cnt - base), 32'd1);

        // Reset at SHIFT cycle 5 aborts with no done pulse.
        @(negedge clk);
        base       = done_cnt;
        bus.start  = 1'b1;
        bus.bcd_in = 12'h500;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("midreset_no_done", 32'(done_cnt - base), 32'd0);
        v = '{bcd: 12'h042, bin: 10'd42, err: 1'b0, lat: LAT};
        run_conv(v, "after_reset");

`ifdef BCD_DIGIT_CHECK_EN
        v = '{bcd: 12'h9A5, bin: 10'd0, err: 1'b1, lat: 1};
        run_conv(v, "invalid");
        v = '{bcd: 12'h010, bin: 10'd10, err: 1'b0, lat: LAT};
        run_conv(v, "valid_after_invalid");
`endif

        // Back-to-back with start held high.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h001;
        t_prev     = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            seen = 1'b0;
            while (n < 40 && !seen) begin
                @(posedge clk);
                #1;
                n++;
                if (bus.done === 1'b1) seen = 1'b1;
            end
            check($sformatf("b2b%0d_seen", k), 32'(seen), 32'd1);
            check($sformatf("b2b%0d_bin", k), 32'(bus.bin_out), 32'(k + 1));
            if (k > 0) begin
                check($sformatf("b2b%0d_spacing", k), 32'(cyc - t_prev), 32'(4 * DIGITS + 3));
            end
            t_prev     = cyc;
            bus.bcd_in = 12'(k + 2);
        end
        bus.start = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
